// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: burst PRBS word source with a valid/ready stream output
// Optional feature: define LFSR_PRBS_GEN_ERR_INJECT_EN to add the inject_err bit-0 error port.
module lfsr_prbs_gen #(
   parameter int                    LFSR_WIDTH  = 31,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
   parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
   parameter                        LFSR_CONFIG = "FIBONACCI",
   parameter bit                    REVERSE     = 1'b0,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    LEN_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   input  logic                  seed_load,
   input  logic [LFSR_WIDTH-1:0] seed_in,
`ifdef LFSR_PRBS_GEN_ERR_INJECT_EN
   input  logic                  inject_err,
`endif
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           word_count
);
   localparam int W = LFSR_WIDTH;
   localparam int D = DATA_WIDTH;
   localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

   // Polynomial bit i weights the bit that is W-i steps old; in the left-shifting
   // Fibonacci register that bit sits at position W-1-i, so taps are the mirror image.
   function automatic logic [W-1:0] rev_bits(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   localparam logic [W-1:0] TAPS = rev_bits(LFSR_POLY);

   // Steps the serial LFSR D times; returns {advanced state, packed word}.
   function automatic logic [W+D-1:0] prbs_step(input logic [W-1:0] s_in);
      logic [W-1:0] s;
      logic [D-1:0] w;
      logic         b;
      s = s_in;
      w = '0;
      for (int i = 0; i < D; i++) begin
         b = s[W-1];
         w = REVERSE ? ((w >> 1) | (D'(b) << (D-1))) : ((w << 1) | D'(b));
         s = GALOIS ? ((s << 1) ^ (b ? LFSR_POLY : '0)) : {s[W-2:0], ^(s & TAPS)};
      end
      return {s, w};
   endfunction

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t                 fsm, fsm_nx;
   logic [W-1:0]         lfsr, lfsr_src, lfsr_nx;
   logic [D-1:0]         word_nx;
   logic [LEN_WIDTH-1:0] len, idx;
   logic                 stop_pend, hs, fin, load, flip_load, flip_hold;

   assign hs   = m_tvalid && m_tready;
   assign busy = (fsm == RUN);

`ifdef LFSR_PRBS_GEN_ERR_INJECT_EN
   logic err_pend;
   // remember an injection request until a fresh word is loaded to carry it
   always_ff @(posedge clk)
      if (!rst_n) err_pend <= 1'b0;
      else err_pend <= load ? 1'b0 : (m_tvalid && !hs) ? err_pend : (err_pend | inject_err);
   assign flip_load = inject_err | err_pend;
   assign flip_hold = inject_err & m_tvalid & ~hs;
`else
   assign flip_load = 1'b0;
   assign flip_hold = 1'b0;
`endif

   // seed selection, next word, burst termination and next FSM state
   always_comb begin
      lfsr_src = (fsm == IDLE && seed_load) ? ((seed_in == '0) ? LFSR_INIT : seed_in) : lfsr;
      {lfsr_nx, word_nx} = prbs_step(lfsr_src);
      fin = hs && (m_tlast || stop_pend);
      load = (fsm == IDLE) ? start : (hs && !fin);
      fsm_nx = fin ? IDLE : (fsm == IDLE && start) ? RUN : fsm;
   end

   // FSM state register
   always_ff @(posedge clk)
      if (!rst_n) fsm <= IDLE;
      else fsm <= fsm_nx;

   // datapath: LFSR state, output word, burst bookkeeping and counters
   always_ff @(posedge clk)
      if (!rst_n) begin
         lfsr       <= LFSR_INIT;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         len        <= '0;
         idx        <= '0;
         stop_pend  <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         lfsr       <= load ? lfsr_nx : lfsr_src;
         m_tdata    <= load ? (word_nx ^ D'(flip_load)) : (m_tdata ^ D'(flip_hold));
         m_tvalid   <= load || (m_tvalid && !fin);
         m_tlast    <= (fsm == IDLE) ? (start && burst_len == LEN_WIDTH'(1))
                       : fin ? 1'b0
                       : load ? (len != '0 && idx + LEN_WIDTH'(1) == len) : m_tlast;
         len        <= (fsm == IDLE && start) ? burst_len : len;
         idx        <= (fsm == IDLE) ? LEN_WIDTH'(1) : idx + LEN_WIDTH'(load);
         stop_pend  <= (fsm == RUN) && !fin && (stop_pend || stop);
         done       <= fin;
         word_count <= word_count + 32'(hs);
      end
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen: directed + randomized checks of lfsr_prbs_gen against a bit-stream recurrence model
module tb_lfsr_prbs_gen;
   localparam logic [6:0] POLY = 7'h41;
   localparam logic [6:0] INIT = 7'h7F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0, start = 1'b0, stop = 1'b0, seed_load = 1'b0, m_tready = 1'b1;
   logic        inject_err = 1'b0;
   logic [15:0] burst_len = '0;
   logic [6:0]  seed_in = '0;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast, busy, done;
   logic [31:0] word_count;

   int vecs = 0, errs = 0;
   logic [6:0] mseed = INIT;
   int k = 0, wc = 0, flip_k = -1;

   lfsr_prbs_gen #(
      .LFSR_WIDTH(7), .LFSR_POLY(POLY), .LFSR_INIT(INIT), .LFSR_CONFIG("FIBONACCI"),
      .REVERSE(1'b0), .DATA_WIDTH(8), .LEN_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .burst_len(burst_len),
      .seed_load(seed_load), .seed_in(seed_in),
`ifdef LFSR_PRBS_GEN_ERR_INJECT_EN
      .inject_err(inject_err),
`endif
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .busy(busy), .done(done), .word_count(word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // Word k (0-based) of the stream from a seed: bits a[0..6] are the seed MSB first,
   // then a[n+7] = sum of POLY[i]*a[n+i] (characteristic x^7 + POLY); words are MSB first.
   function automatic logic [7:0] ref_word(input logic [6:0] seed, input int kk);
      bit a [0:4095];
      logic [7:0] w;
      for (int n = 0; n < 8*kk + 8; n++) begin
         if (n < 7) a[n] = seed[6-n];
         else begin
            a[n] = 1'b0;
            for (int i = 0; i < 7; i++) if (POLY[i]) a[n] ^= a[n-7+i];
         end
      end
      for (int j = 0; j < 8; j++) w[7-j] = a[8*kk + j];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock from negedge to negedge; checks presented data, tracks transfers
   task automatic adv();
      logic hs;
      if (m_tvalid) chk("data", m_tdata, ref_word(mseed, k) ^ ((k == flip_k) ? 8'h01 : 8'h00));
      hs = m_tvalid && m_tready && rst_n;
      @(negedge clk);
      if (hs) begin k++; wc++; end
   endtask

   task automatic burst(input int len);
      chk("pre_valid", m_tvalid, 1'b0);
      start = 1'b1; burst_len = 16'(len); m_tready = 1'b1;
      adv();
      start = 1'b0; seed_load = 1'b0;
      for (int i = 0; i < len; i++) begin
         chk("valid", m_tvalid, 1'b1);
         chk("busy", busy, 1'b1);
         chk("tlast", m_tlast, i == len - 1);
         chk("no_done", done, 1'b0);
         adv();
      end
      chk("end_valid", m_tvalid, 1'b0);
      chk("done", done, 1'b1);
      adv();
      chk("done_pulse", done, 1'b0);
      chk("word_count", word_count, wc);
   endtask

   initial begin
      int n, cnt;
      logic stalled;
      logic hs;
      logic [7:0] pd, w1, w128;
      logic [6:0] s;
      repeat (2) @(negedge clk);
      chk("rst_valid", m_tvalid, 1'b0);
      chk("rst_last", m_tlast, 1'b0);
      chk("rst_data", m_tdata, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wc", word_count, 0);
      rst_n = 1'b1;
      adv();
      burst(3);
      chk("wc3", word_count, 3);

      // random ready over a 20-word burst; start/seed_load mid-burst must be ignored
      burst_len = 16'd20; start = 1'b1; m_tready = 1'b0;
      adv();
      start = 1'b0; n = 0;
      for (int c = 0; c < 400 && n < 20; c++) begin
         m_tready = 1'($urandom_range(0, 1));
         start = (c == 5); seed_load = (c == 5);
         burst_len = (c == 5) ? 16'd2 : 16'd20;
         seed_in = 7'($urandom_range(1, 127));
         stalled = m_tvalid && !m_tready;
         hs = m_tvalid && m_tready;
         if (hs) chk("tlast20", m_tlast, n == 19);
         pd = m_tdata;
         adv();
         if (hs) n++;
         if (stalled) chk("stall_hold", {m_tvalid, m_tdata}, {1'b1, pd});
      end
      start = 1'b0; seed_load = 1'b0; m_tready = 1'b1;
      chk("burst20_count", n, 20);
      chk("burst20_end", m_tvalid, 1'b0);
      chk("burst20_done", done, 1'b1);
      adv();
      chk("wc23", word_count, wc);

      // continuous: period 127 words, then stop allows exactly one more transfer
      burst_len = 16'd0; start = 1'b1;
      adv();
      start = 1'b0;
      for (int i = 0; i < 128; i++) begin
         if (i == 0) w1 = m_tdata;
         if (i == 127) w128 = m_tdata;
         chk("cont_last", m_tlast, 1'b0);
         adv();
      end
      chk("period", w128, w1);
      stop = 1'b1;
      adv();
      stop = 1'b0; cnt = 0;
      for (int c = 0; c < 10 && m_tvalid; c++) begin
         cnt++;
         adv();
      end
      chk("stop_extra", cnt, 1);
      chk("stop_done", done, 1'b1);
      chk("stop_busy", busy, 1'b0);
      adv();

      // zero seed loads the init value
      seed_load = 1'b1; seed_in = 7'h00;
      adv();
      seed_load = 1'b0; mseed = INIT; k = 0;
      burst(4);

      // seed and start in the same cycle: first word comes from the new seed
      s = 7'($urandom_range(1, 127));
      seed_load = 1'b1; seed_in = s; mseed = s; k = 0;
      burst(5);

      // reset mid-burst after 5 words
      burst_len = 16'd0; start = 1'b1;
      adv();
      start = 1'b0;
      repeat (5) adv();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", m_tvalid, 1'b0);
      chk("mid_rst_wc", word_count, 0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      rst_n = 1'b1; mseed = INIT; k = 0; wc = 0;
      adv();
      chk("post_rst_done", done, 1'b0);
      burst(6);

`ifdef LFSR_PRBS_GEN_ERR_INJECT_EN
      burst_len = 16'd6; start = 1'b1;
      adv();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         inject_err = (i == 2);
         if (i == 2) flip_k = k + 1;
         adv();
      end
      inject_err = 1'b0;
      chk("inj_done", done, 1'b1);
      flip_k = -1;
      adv();
      burst(3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
